// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops with the result registered one edge after accept, plus an iterative shift-add MUL.
// MUL result appears 9 cycles after accept; in_ready drops while MUL is busy and upstream must hold its op.
module alu_exec_stage #(
  parameter int DATA_W     = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_s1,
  input  logic [DATA_W-1:0] in_s2,
  input  logic [3:0]        in_rd,
  input  logic              in_set_flags,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] WD,
  output logic [3:0]        rd,
  output logic              reg_write,
  output logic [3:0]        conditions_flags,
  output logic              cpsr_write
);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h4,
                         OP_LSL = 4'h5, OP_LSR = 4'h6, OP_MUL = 4'h9, OP_CMP = 4'hA,
                         OP_ORR = 4'hC, OP_MOV = 4'hD;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mcand_q, mplier_q, acc_q;
  logic [3:0]          mrd_q;
  logic                ms_q;
  logic                out_valid_q, reg_write_q, cpsr_write_q;
  logic [DATA_W-1:0]   wd_q;
  logic [3:0]          rd_q;
  logic [3:0]          flags_q;

  logic [DATA_W-1:0]   res_d;
  logic                c_d, v_d, rw_d, cw_d;
  logic [DATA_W:0]     wide_d;
  logic [DATA_W-1:0]   acc_d;
  logic                accept;

  assign in_ready         = (state_q == IDLE);
  assign accept           = in_valid & in_ready & ~flush;
  assign out_valid        = out_valid_q;
  assign WD               = wd_q;
  assign rd               = rd_q;
  assign reg_write        = reg_write_q;
  assign cpsr_write       = cpsr_write_q;
  assign conditions_flags = flags_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Flags order in flags_q is {N,Z,C,V}; untouched C/V fall through from flags_q.
  always_comb begin
    res_d  = '0;
    c_d    = flags_q[1];
    v_d    = flags_q[0];
    wide_d = '0;
    rw_d   = 1'b1;
    cw_d   = in_set_flags;
    unique case (in_opcode)
      OP_AND: res_d = in_s1 & in_s2;
      OP_EOR: res_d = in_s1 ^ in_s2;
      OP_ORR: res_d = in_s1 | in_s2;
      OP_MOV: res_d = in_s2;
      OP_ADD: begin
        wide_d = {1'b0, in_s1} + {1'b0, in_s2};
        res_d  = wide_d[DATA_W-1:0];
        c_d    = wide_d[DATA_W];
        v_d    = (in_s1[DATA_W-1] == in_s2[DATA_W-1]) && (res_d[DATA_W-1] != in_s1[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        res_d = in_s1 - in_s2;
        c_d   = (in_s1 >= in_s2);
        v_d   = (in_s1[DATA_W-1] != in_s2[DATA_W-1]) && (res_d[DATA_W-1] != in_s1[DATA_W-1]);
        if (in_opcode == OP_CMP) begin
          rw_d = 1'b0;
          cw_d = 1'b1;
        end
      end
      OP_LSL: begin
        wide_d = {1'b0, in_s1} << in_s2[2:0];
        res_d  = wide_d[DATA_W-1:0];
        if (in_s2[2:0] != 3'd0) c_d = wide_d[DATA_W];
      end
      OP_LSR: begin
        wide_d = {in_s1, 1'b0} >> in_s2[2:0];
        res_d  = wide_d[DATA_W:1];
        if (in_s2[2:0] != 3'd0) c_d = wide_d[0];
      end
      default: begin
        rw_d = 1'b0;
        cw_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      mrd_q        <= '0;
      ms_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      cpsr_write_q <= 1'b0;
      wd_q         <= '0;
      rd_q         <= '0;
      flags_q      <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      cpsr_write_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept && in_opcode == OP_MUL) begin
            state_q  <= BUSY;
            cnt_q    <= '0;
            mcand_q  <= in_s1;
            mplier_q <= in_s2;
            acc_q    <= '0;
            mrd_q    <= in_rd;
            ms_q     <= in_set_flags;
          end else if (accept) begin
            out_valid_q  <= 1'b1;
            wd_q         <= res_d;
            rd_q         <= in_rd;
            reg_write_q  <= rw_d;
            cpsr_write_q <= cw_d;
            if (cw_d) flags_q <= {res_d[DATA_W-1], res_d == '0, c_d, v_d};
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q      <= IDLE;
              cnt_q        <= '0;
              out_valid_q  <= 1'b1;
              wd_q         <= acc_d;
              rd_q         <= mrd_q;
              reg_write_q  <= 1'b1;
              cpsr_write_q <= ms_q;
              if (ms_q) flags_q <= {acc_d[DATA_W-1], acc_d == '0, flags_q[1:0]};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
